prog_encoder: RTL and testbench

//  Instruction-side counterpart of the opcode decoder. Accepts symbolic ops (op select + register/immediate fields)
//  and packs each into a 32-bit R-type or D-type word. Opcode values come from the `ADD/`SUB/`AND/`XOR/`ORR/`LDUR/`STUR

---
 rtl/prog_enc_pkg.sv | 73 +++++++
 rtl/prog_enc_if.sv | 33 +++
 rtl/prog_enc_fifo.sv | 54 +++++
 rtl/prog_encoder.sv | 145 ++++++++++++++
 tb/tb_prog_encoder.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_enc_pkg.sv
// Shared types and helpers for the program encoder.
// Opcode values come from the ADD/SUB/AND/XOR/ORR/LDUR/STUR macros of define.v;
// the fallbacks below only apply when define.v is not part of the build.
`ifndef ADD
`define ADD  11'b10001011000
`endif
`ifndef SUB
`define SUB  11'b11001011000
`endif
`ifndef AND
`define AND  11'b10001010000
`endif
`ifndef XOR
`define XOR  11'b11001010000
`endif
`ifndef ORR
`define ORR  11'b10101010000
`endif
`ifndef LDUR
`define LDUR 11'b11111000010
`endif
`ifndef STUR
`define STUR 11'b11111000000
`endif

package prog_enc_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_XOR  = 3'd3,
    OP_ORR  = 3'd4,
    OP_LDUR = 3'd5,
    OP_STUR = 3'd6,
    OP_RSVD = 3'd7
  } op_sel_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int OPC_LSB = 21;
  localparam int RM_LSB  = 16;
  localparam int IMM_LSB = 12;
  localparam int RN_LSB  = 5;
  localparam int RD_LSB  = 0;

  // Loads and stores use the D-type layout; everything else is R-type.
  function automatic logic is_dtype(input op_sel_t op);
    return (op == OP_LDUR) || (op == OP_STUR);
  endfunction

  // The reserved select maps onto ADD so it can become a harmless no-op.
  function automatic logic [10:0] opcode_of(input op_sel_t op);
    logic [10:0] opc;
    case (op)
      OP_ADD:  opc = `ADD;
      OP_SUB:  opc = `SUB;
      OP_AND:  opc = `AND;
      OP_XOR:  opc = `XOR;
      OP_ORR:  opc = `ORR;
      OP_LDUR: opc = `LDUR;
      OP_STUR: opc = `STUR;
      default: opc = `ADD;
    endcase
    return opc;
  endfunction

endpackage

// File: rtl/prog_enc_if.sv
// Op-in / word-out bundle between a program source, the encoder and the
// instruction-memory loader. The master drives ops and accepts words.
interface prog_enc_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [2:0]        in_op;
  logic [4:0]        in_rd;
  logic [4:0]        in_rn;
  logic [4:0]        in_rm;
  logic [8:0]        in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [31:0]       out_data;
  logic [ADDR_W-1:0] inst_count;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, in_valid, in_last, in_op, in_rd, in_rn, in_rm, in_imm, out_ready,
    input  in_ready, out_valid, out_addr, out_data, inst_count, busy, done, err
  );

  modport slave (
    input  start, in_valid, in_last, in_op, in_rd, in_rn, in_rm, in_imm, out_ready,
    output in_ready, out_valid, out_addr, out_data, inst_count, busy, done, err
  );
endinterface

// File: rtl/prog_enc_fifo.sv
// Encoded-word FIFO. The head entry is read straight from the storage
// registers, so a word written at one edge is visible right after it.
module prog_enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == (PTR_W + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; push and pop together leave count alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/prog_encoder.sv
// Program encoder: packs symbolic ops into 32-bit R/D-type words, buffers
// them and streams {addr, word} to the instruction-memory loader.
// Optional feature macro: PROG_ENC_ILLEGAL_CHK_EN -- when defined, op 7 is
// consumed without producing a word and raises the sticky err flag; when
// undefined, op 7 becomes ADD X31,X31,X31 and err stays low.
module prog_encoder
  import prog_enc_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  parameter int BASE   = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  prog_enc_if.slave      bus
);

  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE);

  state_t            state;
  state_t            next_state;
  op_sel_t           op_sel;
  logic [31:0]       enc_word;
  logic [31:0]       head_word;
  logic              in_ready;
  logic              in_fire;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              session_start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] out_addr;
  logic [ADDR_W-1:0] inst_count;
  logic              err;

  assign op_sel        = op_sel_t'(bus.in_op);
  assign in_fire       = bus.in_valid && in_ready;
  assign pop           = !empty && bus.out_ready;
  assign session_start = (state == S_IDLE) && bus.start;

`ifdef PROG_ENC_ILLEGAL_CHK_EN
  assign push = in_fire && (op_sel != OP_RSVD);
`else
  assign push = in_fire;
`endif

  // Pack the op fields into the R-type or D-type layout.
  always_comb begin
    enc_word = '0;
    enc_word[OPC_LSB +: 11] = opcode_of(op_sel);
    enc_word[RN_LSB  +: 5]  = bus.in_rn;
    enc_word[RD_LSB  +: 5]  = bus.in_rd;
    if (is_dtype(op_sel)) begin
      enc_word[IMM_LSB +: 9] = bus.in_imm;
    end else begin
      enc_word[RM_LSB +: 5] = bus.in_rm;
    end
`ifndef PROG_ENC_ILLEGAL_CHK_EN
    if (op_sel == OP_RSVD) begin
      enc_word[RM_LSB +: 5] = 5'd31;
      enc_word[RN_LSB +: 5] = 5'd31;
      enc_word[RD_LSB +: 5] = 5'd31;
    end
`endif
  end

  prog_enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (enc_word),
    .pop       (pop),
    .pop_data  (head_word),
    .full      (full),
    .empty     (empty)
  );

  // Session state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Session sequencing plus the status strobes derived from the state.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (bus.start) next_state = S_LOAD;
      end
      S_LOAD: begin
        in_ready = !full;
        if (bus.in_valid && !full && bus.in_last) next_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (empty) next_state = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Byte address and word count advance on every accepted output word.
  always_ff @(posedge clk) begin
    if (!rst_n || session_start) begin
      out_addr   <= BASE_ADDR;
      inst_count <= '0;
    end else if (pop) begin
      out_addr   <= out_addr + ADDR_W'(4);
      inst_count <= inst_count + 1'b1;
    end
  end

`ifdef PROG_ENC_ILLEGAL_CHK_EN
  // Sticky flag for a reserved op seen during a session.
  always_ff @(posedge clk) begin
    if (!rst_n || session_start) err <= 1'b0;
    else if (in_fire && (op_sel == OP_RSVD)) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = !empty;
  assign bus.out_data   = head_word;
  assign bus.out_addr   = out_addr;
  assign bus.inst_count = inst_count;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.err        = err;

endmodule

// File: tb/tb_prog_encoder.sv
// Directed bench for prog_encoder: a scoreboard of expected {addr, word}
// pairs is filled as ops are accepted and drained as the loader side takes
// words. A second instance uses ADDR_W=4, BASE=8 to exercise address wrap.
module tb_prog_encoder;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  sb_t  sb_q[$];
  logic [7:0] exp_addr = 8'd0;

  always #5 clk = ~clk;

  prog_enc_if #(.ADDR_W(8)) bus_a ();
  prog_enc_if #(.ADDR_W(4)) bus_b ();

  prog_encoder #(.DEPTH(4), .ADDR_W(8), .BASE(0)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  prog_encoder #(.DEPTH(4), .ADDR_W(4), .BASE(8)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  function automatic logic [31:0] ref_word(input logic [2:0] op, input logic [4:0] rd,
                                           input logic [4:0] rn, input logic [4:0] rm,
                                           input logic [8:0] imm);
    logic [10:0] opc;
    case (op)
      3'd0: opc = 11'b10001011000;
      3'd1: opc = 11'b11001011000;
      3'd2: opc = 11'b10001010000;
      3'd3: opc = 11'b11001010000;
      3'd4: opc = 11'b10101010000;
      3'd5: opc = 11'b11111000010;
      3'd6: opc = 11'b11111000000;
      default: opc = 11'b10001011000;
    endcase
    if (op == 3'd5 || op == 3'd6) return {opc, imm, 2'b00, rn, rd};
    if (op == 3'd7) return {opc, 5'd31, 6'd0, 5'd31, 5'd31};
    return {opc, rm, 6'd0, rn, rd};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a();
    tick();
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    exp_addr = 8'd0;
  endtask

  // Present one op, wait for in_ready, record its expected word.
  task automatic send_op(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rn,
                         input logic [4:0] rm, input logic [8:0] imm, input logic last);
    bit ok;
    bit will_push;
    tick();
    bus_a.in_valid = 1'b1;
    bus_a.in_op    = op;
    bus_a.in_rd    = rd;
    bus_a.in_rn    = rn;
    bus_a.in_rm    = rm;
    bus_a.in_imm   = imm;
    bus_a.in_last  = last;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus_a.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    compared++;
    assert (ok) else begin
      mismatched++;
      $error("[TB] FAIL in_ready_timeout: observed 0 expected 1");
    end
`ifdef PROG_ENC_ILLEGAL_CHK_EN
    will_push = (op != 3'd7);
`else
    will_push = 1'b1;
`endif
    if (ok && will_push) begin
      sb_q.push_back('{addr: exp_addr, data: ref_word(op, rd, rn, rm, imm)});
      exp_addr = exp_addr + 8'd4;
    end
    @(posedge clk);
    #1;
    bus_a.in_valid = 1'b0;
    bus_a.in_last  = 1'b0;
  endtask

  // Run a fixed window and report how many done pulses were seen.
  task automatic wait_done(output int pulses);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_a.done) pulses++;
    end
  endtask

  // Scoreboard drain: every word the loader takes must match the queue head.
  always @(negedge clk) begin
    if (rst_n && bus_a.out_valid && bus_a.out_ready) begin
      if (sb_q.size() == 0) begin
        compared++;
        mismatched++;
        $error("[TB] FAIL sb_unexpected: observed word %0h expected none", bus_a.out_data);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check("sb_data", bus_a.out_data, e.data);
        check("sb_addr", 32'(bus_a.out_addr), 32'(e.addr));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses;
    int seen_done;
    int seen_valid;

    bus_a.start = 0; bus_a.in_valid = 0; bus_a.in_last = 0; bus_a.in_op = 0;
    bus_a.in_rd = 0; bus_a.in_rn = 0; bus_a.in_rm = 0; bus_a.in_imm = 0; bus_a.out_ready = 0;
    bus_b.start = 0; bus_b.in_valid = 0; bus_b.in_last = 0; bus_b.in_op = 0;
    bus_b.in_rd = 0; bus_b.in_rn = 0; bus_b.in_rm = 0; bus_b.in_imm = 0; bus_b.out_ready = 0;

    // Reset state.
    tick(); tick();
    @(negedge clk);
    check("rst_busy", 32'(bus_a.busy), 32'd0);
    check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus_a.in_ready), 32'd0);
    check("rst_done", 32'(bus_a.done), 32'd0);
    check("rst_err", 32'(bus_a.err), 32'd0);
    check("rst_count", 32'(bus_a.inst_count), 32'd0);
    check("rst_addr", 32'(bus_a.out_addr), 32'd0);
    check("rst_addr_b", 32'(bus_b.out_addr), 32'd8);
    tick();
    rst_n = 1'b1;

    // Single ADD session.
    bus_a.out_ready = 1'b1;
    start_a();
    @(negedge clk);
    check("load_busy", 32'(bus_a.busy), 32'd1);
    check("load_in_ready", 32'(bus_a.in_ready), 32'd1);
    send_op(3'd0, 5'd1, 5'd2, 5'd3, 9'd0, 1'b1);
    wait_done(pulses);
    check("add_done_pulses", 32'(pulses), 32'd1);
    check("add_count", 32'(bus_a.inst_count), 32'd1);
    check("add_idle", 32'(bus_a.busy), 32'd0);
    check("add_sb_empty", 32'(sb_q.size()), 32'd0);

    // LDUR then STUR.
    start_a();
    send_op(3'd5, 5'd5, 5'd6, 5'd0, 9'h1F0, 1'b0);
    send_op(3'd6, 5'd7, 5'd6, 5'd0, 9'h008, 1'b1);
    wait_done(pulses);
    check("dt_done_pulses", 32'(pulses), 32'd1);
    check("dt_count", 32'(bus_a.inst_count), 32'd2);
    check("dt_sb_empty", 32'(sb_q.size()), 32'd0);

    // Back-pressure: fill the FIFO, hold, then release.
    bus_a.out_ready = 1'b0;
    start_a();
    send_op(3'd1, 5'd1, 5'd2, 5'd3, 9'd0, 1'b0);
    send_op(3'd2, 5'd4, 5'd5, 5'd6, 9'd0, 1'b0);
    send_op(3'd3, 5'd7, 5'd8, 5'd9, 9'd0, 1'b0);
    send_op(3'd4, 5'd10, 5'd11, 5'd12, 9'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_in_ready", 32'(bus_a.in_ready), 32'd0);
      check("full_out_valid", 32'(bus_a.out_valid), 32'd1);
      check("hold_data", bus_a.out_data, sb_q[0].data);
      tick();
    end
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    check("no_bypass", 32'(bus_a.in_ready), 32'd0);
    send_op(3'd0, 5'd13, 5'd14, 5'd15, 9'd0, 1'b1);
    tick();
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    wait_done(pulses);
    check("bp_done_pulses", 32'(pulses), 32'd1);
    check("bp_count", 32'(bus_a.inst_count), 32'd5);
    check("bp_addr", 32'(bus_a.out_addr), 32'd20);
    check("bp_sb_empty", 32'(sb_q.size()), 32'd0);

    // Address wrap on the narrow instance.
    tick();
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_b.in_valid = 1'b1;
      bus_b.in_op    = 3'd0;
      bus_b.in_rd    = 5'(i);
      bus_b.in_rn    = 5'd2;
      bus_b.in_rm    = 5'd3;
      bus_b.in_last  = (i == 2);
      @(negedge clk);
      check("wrap_in_ready", 32'(bus_b.in_ready), 32'd1);
      tick();
    end
    bus_b.in_valid  = 1'b0;
    bus_b.in_last   = 1'b0;
    bus_b.out_ready = 1'b1;
    @(negedge clk);
    check("wrap_addr0", 32'(bus_b.out_addr), 32'd8);
    check("wrap_data0", bus_b.out_data, ref_word(3'd0, 5'd0, 5'd2, 5'd3, 9'd0));
    tick();
    @(negedge clk);
    check("wrap_addr1", 32'(bus_b.out_addr), 32'd12);
    tick();
    @(negedge clk);
    check("wrap_addr2", 32'(bus_b.out_addr), 32'd0);
    tick();
    @(negedge clk);
    check("wrap_count", 32'(bus_b.inst_count), 32'd3);
    check("wrap_addr_after", 32'(bus_b.out_addr), 32'd4);

    // Reset while draining with two words buffered.
    bus_a.out_ready = 1'b0;
    start_a();
    send_op(3'd0, 5'd1, 5'd1, 5'd1, 9'd0, 1'b0);
    send_op(3'd1, 5'd2, 5'd2, 5'd2, 9'd0, 1'b1);
    @(negedge clk);
    check("drain_busy", 32'(bus_a.busy), 32'd1);
    check("drain_out_valid", 32'(bus_a.out_valid), 32'd1);
    tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("mid_rst_busy", 32'(bus_a.busy), 32'd0);
    check("mid_rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("mid_rst_count", 32'(bus_a.inst_count), 32'd0);
    tick();
    rst_n = 1'b1;
    sb_q.delete();
    bus_a.out_ready = 1'b1;
    seen_done = 0;
    seen_valid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus_a.done) seen_done++;
      if (bus_a.out_valid) seen_valid++;
    end
    check("mid_rst_no_done", 32'(seen_done), 32'd0);
    check("mid_rst_no_valid", 32'(seen_valid), 32'd0);

    // Reserved op in the middle of a stream.
    start_a();
    send_op(3'd0, 5'd4, 5'd4, 5'd4, 9'd0, 1'b0);
    send_op(3'd7, 5'd9, 5'd9, 5'd9, 9'd0, 1'b0);
    send_op(3'd1, 5'd5, 5'd5, 5'd5, 9'd0, 1'b1);
    wait_done(pulses);
    check("rsvd_done_pulses", 32'(pulses), 32'd1);
`ifdef PROG_ENC_ILLEGAL_CHK_EN
    check("rsvd_err", 32'(bus_a.err), 32'd1);
    check("rsvd_count", 32'(bus_a.inst_count), 32'd2);
`else
    check("rsvd_err", 32'(bus_a.err), 32'd0);
    check("rsvd_count", 32'(bus_a.inst_count), 32'd3);
`endif
    check("rsvd_sb_empty", 32'(sb_q.size()), 32'd0);

    // A new session clears err; in_last on a reserved op still closes LOAD.
    start_a();
    @(negedge clk);
    check("start_clears_err", 32'(bus_a.err), 32'd0);
    send_op(3'd7, 5'd1, 5'd1, 5'd1, 9'd0, 1'b1);
    wait_done(pulses);
    check("rsvd_last_done", 32'(pulses), 32'd1);
    check("rsvd_last_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
